// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipeline hazard/coprocessor controller.
//   - cop_state_e : coprocessor handshake FSM states (also the debug encoding)
//   - FWD_*       : E-stage operand mux select encodings
//   - REG_AW_DEF  : default register-address width
//   Optional feature macro used by the controller files: PIPE_FORWARD_EN.
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_COP_WAIT = 2'd1,
        ST_COP_DONE = 2'd2
    } cop_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_W  = 2'b01;  // operand from W-stage result
    localparam logic [1:0] FWD_M  = 2'b10;  // operand from M-stage result

endpackage

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
//   Purely combinational data-hazard logic for a 5-stage pipeline.
//   Macro PIPE_FORWARD_EN selects the operating mode:
//     defined   : M/W -> E operand forwarding; only a load-use hazard stalls.
//     undefined : no forwarding (selects tied to FWD_RF); any RAW dependence of
//                 a D-stage source on a pending E or M write stalls.
//   Register x0 never produces a stall or a forward.
// Ports
//   rs1_d, rs2_d      : D-stage source registers
//   rs1_e, rs2_e      : E-stage source registers
//   rd_e, rd_m, rd_w  : destination registers of E, M, W
//   reg_write_e/m/w   : the corresponding stage writes its rd
//   load_e            : E-stage instruction is a load
//   forward_a_e/b_e   : E-stage operand mux selects (FWD_* encodings)
//   data_stall        : D-stage must hold (F/D stall, E bubble)
// ---------------------------------------------------------------------------
module hazard_fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_e,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              load_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              data_stall
);

    logic lw_stall;

    // A load's data only exists after M, so a dependent instruction in D must
    // wait one cycle regardless of forwarding.
    assign lw_stall = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

`ifdef PIPE_FORWARD_EN

    // M is the younger producer, so it takes precedence over W.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              wr_m,
        input logic [REG_AW-1:0] dst_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] dst_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (wr_m && (dst_m != '0) && (dst_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (dst_w != '0) && (dst_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    always_comb begin
        forward_a_e = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
        forward_b_e = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
        data_stall  = lw_stall;
    end

    // With forwarding, an E-stage write is resolved by the M/W paths.
    logic unused_sig;
    assign unused_sig = reg_write_e;

`else

    function automatic logic raw_hit(
        input logic [REG_AW-1:0] rs,
        input logic              wr_e,
        input logic [REG_AW-1:0] dst_e,
        input logic              wr_m,
        input logic [REG_AW-1:0] dst_m
    );
        return (rs != '0) && ((wr_e && (dst_e == rs)) || (wr_m && (dst_m == rs)));
    endfunction

    always_comb begin
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        // W is not checked: the register file writes before it is read.
        data_stall  = raw_hit(rs1_d, reg_write_e, rd_e, reg_write_m, rd_m)
                    || raw_hit(rs2_d, reg_write_e, rd_e, reg_write_m, rd_m)
                    || lw_stall;
    end

    // E-stage sources and the W write port only feed the forwarding network.
    logic unused_sig;
    assign unused_sig = ^{rs1_e, rs2_e, rd_w, reg_write_w};

`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Pipeline hazard controller with a coprocessor (CNN) handshake FSM.
//   Combines data hazards (from hazard_fwd_unit), taken-branch flushes and a
//   RUN / COP_WAIT / COP_DONE coprocessor FSM with a timeout.
//   Priority: coprocessor stall > branch flush > data-hazard stall.
//   Optional feature macro: PIPE_FORWARD_EN (enables M/W -> E forwarding).
// Parameters
//   TIMEOUT_CYCLES : max cycles spent in COP_WAIT before abort (2..255)
//   REG_AW         : register-address width
// Ports
//   clk, reset                    : clock; async active-low reset
//   Rs1D..RdW, RegWrite*, LoadE   : hazard inputs per stage
//   PCSrcE                        : taken branch/jump resolved in E
//   CopReqE, cop_done             : coprocessor request in E, completion pulse
//   StallF/D/E, FlushD/E/M        : pipeline register hold / bubble controls
//   ForwardAE/BE                  : E-stage operand selects
//   cop_start                     : one-cycle launch pulse
//   cop_busy, cop_err             : FSM not in RUN; sticky timeout flag
//   cop_state                     : debug view of the FSM state (cop_state_e)
// Handshake: the coprocessor is launched by the single RUN cycle where
// CopReqE=1 and PCSrcE=0 (cop_start=1); any cop_done pulse seen while in
// COP_WAIT completes the operation, pulses at other times are ignored.
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int REG_AW         = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              LoadE,
    input  logic              PCSrcE,
    input  logic              CopReqE,
    input  logic              cop_done,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              cop_start,
    output logic              cop_busy,
    output logic              cop_err,
    output logic [1:0]        cop_state
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    cop_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       launch;

    logic [1:0] fwd_a, fwd_b;
    logic       data_stall;

    hazard_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .rs1_d       (Rs1D),
        .rs2_d       (Rs2D),
        .rs1_e       (Rs1E),
        .rs2_e       (Rs2E),
        .rd_e        (RdE),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_e (RegWriteE),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .load_e      (LoadE),
        .forward_a_e (fwd_a),
        .forward_b_e (fwd_b),
        .data_stall  (data_stall)
    );

    // Next-state logic for the coprocessor FSM and its timeout counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        launch  = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A taken branch squashes the request, so no launch then.
                if (CopReqE && !PCSrcE) begin
                    launch  = 1'b1;
                    state_d = ST_COP_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_COP_WAIT: begin
                if (cop_done) begin
                    state_d = ST_COP_DONE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    state_d = ST_RUN;
                    err_d   = 1'b1;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_COP_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Pipeline controls. Everything is forced low while reset is asserted so
    // the datapath sees no stray stalls, flushes or forwards during reset.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        cop_start = 1'b0;
        if (reset) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            case (state_q)
                ST_RUN: begin
                    if (launch) begin
                        // Freeze F/D/E around the coprocessor instruction and
                        // feed bubbles into M.
                        StallF    = 1'b1;
                        StallD    = 1'b1;
                        StallE    = 1'b1;
                        FlushM    = 1'b1;
                        cop_start = 1'b1;
                    end else if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (data_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                ST_COP_WAIT: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                end
                default: begin
                    // COP_DONE: the coprocessor instruction advances.
                end
            endcase
        end
    end

    assign cop_busy  = busy_q;
    assign cop_err   = err_q;
    assign cop_state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed bench for pipeline_ctrl. Two instances share all inputs:
//   dut0 uses the default timeout (64), dut1 uses TIMEOUT_CYCLES=8.
//   Expectations adapt to the PIPE_FORWARD_EN build option.
//   Observed output word (12 bits):
//     [11] StallF [10] StallD [9] StallE [8] FlushD [7] FlushE [6] FlushM
//     [5] cop_start [4] cop_busy [3:2] ForwardAE [1:0] ForwardBE
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int AW = 5;

`ifdef PIPE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [11:0] O_IDLE   = 12'h000;
    localparam logic [11:0] O_LAUNCH = 12'hE60;
    localparam logic [11:0] O_WAIT   = 12'hE50;
    localparam logic [11:0] O_DONE   = 12'h010;
    localparam logic [11:0] O_BRANCH = 12'h180;
    localparam logic [11:0] O_HAZ    = 12'hC80;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, CopReqE, cop_done;

    logic d0_stall_f, d0_stall_d, d0_stall_e, d0_flush_d, d0_flush_e, d0_flush_m;
    logic [1:0] d0_fwd_a, d0_fwd_b, d0_state;
    logic d0_start, d0_busy, d0_err;
    logic d1_stall_f, d1_stall_d, d1_stall_e, d1_flush_d, d1_flush_e, d1_flush_m;
    logic [1:0] d1_fwd_a, d1_fwd_b, d1_state;
    logic d1_start, d1_busy, d1_err;

    pipeline_ctrl dut0 (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .CopReqE(CopReqE), .cop_done(cop_done),
        .StallF(d0_stall_f), .StallD(d0_stall_d), .StallE(d0_stall_e),
        .FlushD(d0_flush_d), .FlushE(d0_flush_e), .FlushM(d0_flush_m),
        .ForwardAE(d0_fwd_a), .ForwardBE(d0_fwd_b),
        .cop_start(d0_start), .cop_busy(d0_busy), .cop_err(d0_err),
        .cop_state(d0_state)
    );

    pipeline_ctrl #(.TIMEOUT_CYCLES(8)) dut1 (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .CopReqE(CopReqE), .cop_done(cop_done),
        .StallF(d1_stall_f), .StallD(d1_stall_d), .StallE(d1_stall_e),
        .FlushD(d1_flush_d), .FlushE(d1_flush_e), .FlushM(d1_flush_m),
        .ForwardAE(d1_fwd_a), .ForwardBE(d1_fwd_b),
        .cop_start(d1_start), .cop_busy(d1_busy), .cop_err(d1_err),
        .cop_state(d1_state)
    );

    logic [11:0] obs0, obs1;
    assign obs0 = {d0_stall_f, d0_stall_d, d0_stall_e, d0_flush_d, d0_flush_e, d0_flush_m,
                   d0_start, d0_busy, d0_fwd_a, d0_fwd_b};
    assign obs1 = {d1_stall_f, d1_stall_d, d1_stall_e, d1_flush_d, d1_flush_e, d1_flush_m,
                   d1_start, d1_busy, d1_fwd_a, d1_fwd_b};

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic rwe, rwm, rww, ld, pc;
        logic [11:0] exp;
    } vec_t;

    vec_t vec_q[$];

    task automatic add_vec(
        input logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
        input logic rwe, rwm, rww, ld, pc,
        input logic [11:0] exp
    );
        vec_t v;
        v = '{rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, rwe, rwm, rww, ld, pc, exp};
        vec_q.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        LoadE = 1'b0; PCSrcE = 1'b0; CopReqE = 1'b0; cop_done = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
        RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
        RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww;
        LoadE = v.ld; PCSrcE = v.pc; CopReqE = 1'b0; cop_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        int stall_cyc;
        reset = 1'b0;
        idle_inputs();

        //            rs1d rs2d rs1e rs2e rde rdm rdw rwe rwm rww ld pc  expected
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
        add_vec(0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0, FWD ? 12'h008 : O_IDLE); // M beats W
        add_vec(0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 0, 0, FWD ? 12'h004 : O_IDLE); // W only
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, O_IDLE);                 // x0 never forwards
        add_vec(0, 0, 5, 0, 0, 0, 0, 0, 1, 1, 0, 0, O_IDLE);                 // RdM=RdW=0
        add_vec(0, 0, 3, 9, 0, 3, 9, 0, 1, 1, 0, 0, FWD ? 12'h009 : O_IDLE); // A<-M, B<-W
        add_vec(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0, O_HAZ);                  // load-use
        add_vec(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 1, O_BRANCH);               // branch beats load-use
        add_vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, O_IDLE);                 // load to x0
        add_vec(3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, FWD ? O_IDLE : O_HAZ);   // ALU RAW on E
        add_vec(0, 4, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, FWD ? O_IDLE : O_HAZ);   // ALU RAW on M
        add_vec(2, 3, 0, 0, 6, 0, 0, 1, 0, 0, 1, 0, O_IDLE);                 // load, no dependence
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_BRANCH);               // plain branch
        add_vec(8, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0, 0, O_IDLE);                 // W write never stalls
        add_vec(3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 1, O_BRANCH);               // branch beats RAW

        // Outputs held low while in reset, even with hazard inputs present.
        @(negedge clk);
        apply_vec(vec_q[7]);
        Rs1E = 5; RdM = 5; RegWriteM = 1'b1;
        #1;
        check("reset_outputs", {20'd0, obs0}, {20'd0, O_IDLE});
        check("reset_state_err", {29'd0, d0_state, d0_err}, 32'd0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;

        // Table-driven combinational checks (FSM idle in RUN).
        for (int i = 0; i < vec_q.size(); i++) begin
            @(negedge clk);
            apply_vec(vec_q[i]);
            #1;
            check($sformatf("vec[%0d]", i), {20'd0, obs0}, {20'd0, vec_q[i].exp});
        end

        // A taken branch squashes the coprocessor request.
        @(negedge clk);
        idle_inputs();
        CopReqE = 1'b1; PCSrcE = 1'b1;
        #1;
        check("cop_req_with_branch", {20'd0, obs0}, {20'd0, O_BRANCH});
        @(negedge clk);
        idle_inputs();
        #1;
        check("cop_req_with_branch_state", {30'd0, d0_state}, 32'd0);

        // Coprocessor op completing after 10 wait cycles; the request stays
        // asserted, a branch shows up mid-wait, and neither may leak through.
        @(negedge clk);
        idle_inputs();
        stall_cyc = 0;
        CopReqE = 1'b1;
        #1;
        check("cop_launch", {20'd0, obs0}, {20'd0, O_LAUNCH});
        if (d0_stall_f) stall_cyc++;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            cop_done = (c == 10);
            PCSrcE   = (c == 5);
            #1;
            check($sformatf("cop_wait[%0d]", c), {20'd0, obs0}, {20'd0, O_WAIT});
            check($sformatf("cop_wait_state[%0d]", c), {30'd0, d0_state}, 32'd1);
            if (d0_stall_f) stall_cyc++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("cop_stall_cycles", stall_cyc, 32'd11);
        check("cop_done_outputs", {20'd0, obs0}, {20'd0, O_DONE});
        check("cop_done_state", {30'd0, d0_state}, 32'd2);
        @(negedge clk);
        cop_done = 1'b1;  // stray pulse in RUN is ignored
        #1;
        check("cop_back_run", {20'd0, obs0, d0_state, d0_err}, {20'd0, O_IDLE, 3'b000});
        @(negedge clk);
        cop_done = 1'b0;
        #1;
        check("stray_done_ignored", {29'd0, d0_state, d0_busy}, 32'd0);

        // Timeout on the 8-cycle instance.
        do_reset();
        @(negedge clk);
        CopReqE = 1'b1;
        #1;
        check("to_launch", {20'd0, obs1}, {20'd0, O_LAUNCH});
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            CopReqE = 1'b0;
            #1;
            check($sformatf("to_wait[%0d]", c), {20'd0, obs1, d1_state}, {20'd0, O_WAIT, 2'd1});
        end
        @(negedge clk);
        #1;
        check("to_return_run", {20'd0, obs1, d1_state}, {20'd0, O_IDLE, 2'd0});
        check("to_err_set", {31'd0, d1_err}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("to_err_sticky", {31'd0, d1_err}, 32'd1);
        check("to_no_err_default", {31'd0, d0_err}, 32'd0);
        do_reset();
        @(negedge clk);
        #1;
        check("to_err_cleared", {31'd0, d1_err}, 32'd0);

        // Reset asserted in the third COP_WAIT cycle.
        @(negedge clk);
        CopReqE = 1'b1;
        @(negedge clk);
        CopReqE = 1'b0;
        @(negedge clk);
        @(negedge clk);
        Rs1E = 5; RdM = 5; RegWriteM = 1'b1; PCSrcE = 1'b1;
        #1;
        check("rst_mid_pre_state", {30'd0, d0_state}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_outputs", {20'd0, obs0}, {20'd0, O_IDLE});
        check("rst_mid_state_err", {29'd0, d0_state, d0_err}, 32'd0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_after", {20'd0, obs0, d0_state, d0_err}, {20'd0, O_IDLE, 3'b000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, max clk cycles spent in COP_WAIT before abort (range 2..255).
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_AW each  source/dest register indices per stage.
REQ-006 RegWriteE, RegWriteM, RegWriteW  in  1 each  stage writes Rd.
REQ-007 LoadE  in  1  instruction in E is a load (ResultSrcE[0]).
REQ-008 PCSrcE  in  1  taken branch/jump resolved in E.
REQ-009 CopReqE  in  1  coprocessor (CNN) instruction valid in E.
REQ-010 cop_done  in  1  coprocessor completion pulse.
REQ-011 StallF, StallD, StallE  out  1 each  hold the corresponding pipeline register.
REQ-012 FlushD, FlushE, FlushM  out  1 each  clear the corresponding pipeline register to a bubble.
REQ-013 ForwardAE, ForwardBE  out  2 each  E-stage operand mux select: 00 regfile, 01 W result, 10 M result.
REQ-014 cop_start  out  1  one-cycle coprocessor launch pulse.
REQ-015 cop_busy  out  1  FSM not in RUN; cop_err  out  1  sticky timeout flag.

Function
REQ-016 FSM states RUN, COP_WAIT, COP_DONE; registered state, 8-bit timeout counter.
REQ-017 RUN -> COP_WAIT when CopReqE=1 and PCSrcE=0; cop_start=1 for exactly that RUN cycle only.
REQ-018 COP_WAIT -> COP_DONE on cop_done=1; COP_WAIT -> RUN with cop_err set when counter reaches TIMEOUT_CYCLES-1 without cop_done.
REQ-019 COP_DONE -> RUN unconditionally after one cycle; cop_done outside COP_WAIT is ignored.
REQ-020 Counter clears on entry to COP_WAIT, increments each COP_WAIT cycle, saturates, never wraps.
REQ-021 Launch cycle and all COP_WAIT cycles: StallF=StallD=StallE=1, FlushM=1; COP_DONE: all stalls 0 (instruction advances).
REQ-022 Load-use (RUN only): lwStall = LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D); StallF=StallD=lwStall, FlushE=lwStall.
REQ-023 PCSrcE=1 in RUN: FlushD=FlushE=1, StallF=StallD=0 (branch beats load-use).
REQ-024 Priority: coprocessor stall > branch flush > load-use stall.
REQ-025 Forwarding (combinational): 10 if RegWriteM & RdM!=0 & RdM==RsxE; else 01 if RegWriteW & RdW!=0 & RdW==RsxE; else 00; M beats W.
REQ-026 x0 never causes a stall or forward.
REQ-027 cop_err clears only on reset; cop_busy=1 in COP_WAIT and COP_DONE.

Reset
REQ-028 reset=0 asynchronously forces state RUN, counter 0, cop_err 0.
REQ-029 While reset=0 all Stall*/Flush*/cop_start/cop_busy = 0 and Forward*E = 00; reset mid-COP_WAIT abandons the operation without setting cop_err.

Configuration
REQ-030 Macro PIPE_FORWARD_EN defined: forwarding per REQ-025.
REQ-031 PIPE_FORWARD_EN undefined: Forward*E tied 00; RAW stall when Rs1D/Rs2D (nonzero) equals RdE with RegWriteE or RdM with RegWriteM -> StallF=StallD=FlushE=1; load-use rule subsumed.

Structure
REQ-032 Shared package pipe_pkg holds FSM state enum, forward-select encodings (FWD_RF, FWD_W, FWD_M) and REG_AW default.
REQ-033 One sub-module hazard_fwd_unit holds combinational forwarding/RAW detection; FSM and counter live in pipeline_ctrl.

Verification
REQ-034 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; RegWriteM=0 -> 01; RdM=RdW=0 -> 00.
REQ-035 LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 one cycle; add PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
REQ-036 CopReqE=1, cop_done after 10 cycles -> cop_start one pulse, stalls+FlushM high 11 cycles, one COP_DONE cycle, back to RUN, cop_err=0.
REQ-037 TIMEOUT_CYCLES=8, no cop_done -> return to RUN after 8 COP_WAIT cycles, cop_err=1 until reset.
REQ-038 reset=0 asserted during COP_WAIT cycle 3 -> all outputs 0 immediately; after release state RUN, cop_err=0.
REQ-039 PIPE_FORWARD_EN undefined, RegWriteE=1, RdE=3, Rs1D=3 -> StallF=StallD=FlushE=1, ForwardAE=00.
